// File: rtl/key_event_device.sv
// rtl/key_event_device.sv - debounced key input port with event FIFO, overrun flag and level interrupt
// Bus-mapped at DATA/CTRL/EVENT; every accepted input change is queued as {mask, state}.
module key_event_device #(
  parameter int          NBITS      = 4,
  parameter logic [31:0] BASE       = 32'hF000_0010,
  parameter int          DEBOUNCE   = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter bit          INVERT     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] key,
  input  logic [31:0]      abus,
  inout  wire  [31:0]      dbus,
  input  logic             we,
  output logic             intr
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);
  localparam logic [31:0]   CTRL_ADDR = BASE + 32'h100;
  localparam logic [31:0]   EVT_ADDR  = BASE + 32'h200;

  logic [NBITS-1:0]   sync1_q, sync2_q;
  logic [NBITS-1:0]   stable_q, stable_d;
  logic [CW-1:0]      cnt_q [NBITS];
  logic [CW-1:0]      cnt_d [NBITS];
  logic [2*NBITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]      count_q, count_d;
  logic               ovr_q, ovr_d, ie_q, ie_d, press_q, press_d;

  logic [NBITS-1:0]   in_raw, chg, ev_mask;
  logic               push, pop, do_push, overrun, empty, full, ctrl_wr;
  logic [2*NBITS-1:0] head;
  logic [31:0]        rdata;
  logic               drive;
  logic [4:0]         count5;
  logic               unused_dbus;

  assign in_raw = INVERT ? ~key : key;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NBITS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  // In PRESS mode only rising bits are reported, and falling-only changes queue nothing.
  assign chg     = stable_d ^ stable_q;
  assign ev_mask = press_q ? (chg & stable_d) : chg;
  assign push    = |ev_mask;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop     = !we && (abus == EVT_ADDR) && !empty;
  assign do_push = push && (!full || pop);
  assign overrun = push && full && !pop;
  assign ctrl_wr = we && (abus == CTRL_ADDR);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + NW'(do_push) - NW'(pop);
    ie_d     = ie_q;
    press_d  = press_q;
    ovr_d    = ovr_q;
    if (ctrl_wr) begin
      ie_d    = dbus[8];
      press_d = dbus[9];
      if (!dbus[2]) ovr_d = 1'b0;
    end
    if (overrun) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ie_q     <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= in_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ie_q     <= ie_d;
      press_q  <= press_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read out.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr_q] <= {ev_mask, stable_d};
  end

  assign count5 = 5'(count_q);

  always_comb begin
    rdata = '0;
    drive = 1'b0;
    if (!we) begin
      if (abus == BASE) begin
        drive             = 1'b1;
        rdata[NBITS-1:0]  = stable_q;
      end else if (abus == CTRL_ADDR) begin
        drive             = 1'b1;
        rdata[0]          = !empty;
        rdata[2]          = ovr_q;
        rdata[8]          = ie_q;
        rdata[9]          = press_q;
        rdata[20:16]      = count5;
      end else if (abus == EVT_ADDR) begin
        drive = 1'b1;
        if (!empty) begin
          rdata[31]         = 1'b1;
          rdata[16+:NBITS]  = head[2*NBITS-1:NBITS];
          rdata[0+:NBITS]   = head[NBITS-1:0];
        end
      end
    end
  end

  assign dbus        = drive ? rdata : 32'bz;
  assign intr        = ie_q & !empty;
  assign unused_dbus = ^{dbus[31:10], dbus[7:3], dbus[1:0]};

endmodule

// File: tb/tb_key_event_device.sv
// tb/tb_key_event_device.sv - directed table-driven bench for key_event_device
// Bus is pulled up so an undriven dbus reads all ones.
module tb_key_event_device;

  localparam logic [31:0] DATA_A = 32'hF000_0010;
  localparam logic [31:0] CTRL_A = 32'hF000_0110;
  localparam logic [31:0] EVT_A  = 32'hF000_0210;
  localparam int OP_NONE = 0;
  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;

  typedef struct {
    logic [3:0]  key;
    int          wait_n;
    int          op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_intr;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key = 4'hF;
  logic [31:0] abus = 32'h0;
  logic        we = 1'b0;
  logic        intr;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_wdata = 32'h0;
  wire  [31:0] dbus;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  pullup (dbus);
  assign dbus = tb_oe ? tb_wdata : 32'bz;

  key_event_device #(
    .NBITS(4), .BASE(32'hF000_0010), .DEBOUNCE(16), .FIFO_DEPTH(4), .INVERT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .abus(abus), .dbus(dbus), .we(we), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Looks at a register without spending a clock edge.
  task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string name);
    abus = addr;
    we   = 1'b0;
    #1;
    check(name, dbus, exp);
    abus = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_intr, input string name);
    abus = addr;
    we   = 1'b0;
    #1;
    check(name, dbus, exp);
    check({name, "_intr"}, {31'b0, intr}, {31'b0, exp_intr});
    step();
    abus = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    abus     = addr;
    we       = 1'b1;
    tb_oe    = 1'b1;
    tb_wdata = data;
    step();
    we    = 1'b0;
    tb_oe = 1'b0;
    abus  = 32'h0;
  endtask

  initial begin
    // glitch on key[0] while key[1] stays held
    vecs.push_back('{4'hC, 10, OP_NONE, 32'h0,  32'h0,         1'b0, "glitch"});
    vecs.push_back('{4'hD, 20, OP_RD,   DATA_A, 32'h0000_0002, 1'b0, "glitch_data"});
    vecs.push_back('{4'hD, 0,  OP_RD,   CTRL_A, 32'h0000_0000, 1'b0, "glitch_cnt"});
    vecs.push_back('{4'hD, 0,  OP_WR,   DATA_A, 32'h0000_000F, 1'b0, "data_wr"});
    vecs.push_back('{4'hD, 0,  OP_RD,   DATA_A, 32'h0000_0002, 1'b0, "data_wr_ignored"});
    // overrun: five changes into a four-entry FIFO
    vecs.push_back('{4'hD, 0,  OP_WR,   CTRL_A, 32'h0000_0100, 1'b0, "ie_on"});
    vecs.push_back('{4'hF, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "chg1"});
    vecs.push_back('{4'hE, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "chg2"});
    vecs.push_back('{4'hC, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "chg3"});
    vecs.push_back('{4'hD, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "chg4"});
    vecs.push_back('{4'hF, 20, OP_RD,   CTRL_A, 32'h0004_0105, 1'b1, "ovr_full"});
    vecs.push_back('{4'hF, 0,  OP_WR,   CTRL_A, 32'h0000_0104, 1'b0, "ovr_keep_wr"});
    vecs.push_back('{4'hF, 0,  OP_RD,   CTRL_A, 32'h0004_0105, 1'b1, "ovr_keep"});
    vecs.push_back('{4'hF, 0,  OP_WR,   CTRL_A, 32'h0000_0100, 1'b0, "ovr_clr_wr"});
    vecs.push_back('{4'hF, 0,  OP_RD,   CTRL_A, 32'h0004_0101, 1'b1, "ovr_clr"});
    vecs.push_back('{4'hF, 0,  OP_RD,   EVT_A,  32'h8002_0000, 1'b1, "evt0"});
    vecs.push_back('{4'hF, 0,  OP_RD,   EVT_A,  32'h8001_0001, 1'b1, "evt1"});
    vecs.push_back('{4'hF, 0,  OP_RD,   EVT_A,  32'h8002_0003, 1'b1, "evt2"});
    vecs.push_back('{4'hF, 0,  OP_RD,   EVT_A,  32'h8001_0002, 1'b1, "evt3"});
    vecs.push_back('{4'hF, 0,  OP_RD,   CTRL_A, 32'h0000_0100, 1'b0, "empty_ctrl"});
    vecs.push_back('{4'hF, 0,  OP_RD,   EVT_A,  32'h0000_0000, 1'b0, "empty_evt"});
    vecs.push_back('{4'hF, 0,  OP_RD,   CTRL_A, 32'h0000_0100, 1'b0, "empty_nopop"});
    // full FIFO, pop on the same edge as a new push
    vecs.push_back('{4'hE, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "fill1"});
    vecs.push_back('{4'hC, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "fill2"});
    vecs.push_back('{4'hD, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "fill3"});
    vecs.push_back('{4'hF, 20, OP_RD,   CTRL_A, 32'h0004_0101, 1'b1, "full4"});
    vecs.push_back('{4'hE, 17, OP_RD,   EVT_A,  32'h8001_0001, 1'b1, "pushpop_head"});
    vecs.push_back('{4'hE, 0,  OP_RD,   CTRL_A, 32'h0004_0101, 1'b1, "pushpop_cnt"});
    vecs.push_back('{4'hE, 0,  OP_RD,   EVT_A,  32'h8002_0003, 1'b1, "pp_evt1"});
    vecs.push_back('{4'hE, 0,  OP_RD,   EVT_A,  32'h8001_0002, 1'b1, "pp_evt2"});
    vecs.push_back('{4'hE, 0,  OP_RD,   EVT_A,  32'h8002_0000, 1'b1, "pp_evt3"});
    vecs.push_back('{4'hE, 0,  OP_RD,   EVT_A,  32'h8001_0001, 1'b1, "pushpop_last"});
    vecs.push_back('{4'hE, 0,  OP_RD,   CTRL_A, 32'h0000_0100, 1'b0, "pp_empty"});
    // PRESS mode: only the press of key[2] is queued
    vecs.push_back('{4'hE, 0,  OP_WR,   CTRL_A, 32'h0000_0300, 1'b0, "press_on"});
    vecs.push_back('{4'hF, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "rel0"});
    vecs.push_back('{4'hB, 20, OP_NONE, 32'h0,  32'h0,         1'b0, "press2"});
    vecs.push_back('{4'hF, 20, OP_RD,   CTRL_A, 32'h0001_0301, 1'b1, "press_one"});
    vecs.push_back('{4'hF, 0,  OP_RD,   EVT_A,  32'h8004_0004, 1'b1, "press_evt"});
    vecs.push_back('{4'hF, 0,  OP_RD,   CTRL_A, 32'h0000_0300, 1'b0, "press_rel"});

    // reset with all keys released
    rst = 1'b0;
    key = 4'hF;
    repeat (3) step();
    rst = 1'b1;
    peek(DATA_A, 32'h0, "rst_data");
    peek(CTRL_A, 32'h0, "rst_ctrl");
    check("rst_intr", {31'b0, intr}, 32'h0);
    peek(32'h0000_1000, 32'hFFFF_FFFF, "rst_dbus_z");

    // DATA must change on exactly the 18th edge after key[1] goes low
    key = 4'hD;
    repeat (17) step();
    peek(DATA_A, 32'h0, "data_edge17");
    step();
    peek(DATA_A, 32'h2, "data_edge18");
    bus_read(CTRL_A, 32'h0001_0001, 1'b0, "ready_one");
    bus_read(EVT_A,  32'h8002_0002, 1'b0, "evt_first");
    bus_read(CTRL_A, 32'h0000_0000, 1'b0, "ready_drop");

    foreach (vecs[i]) begin
      key = vecs[i].key;
      repeat (vecs[i].wait_n) step();
      case (vecs[i].op)
        OP_RD:   bus_read(vecs[i].addr, vecs[i].data, vecs[i].exp_intr, vecs[i].name);
        OP_WR:   bus_write(vecs[i].addr, vecs[i].data);
        default: ;
      endcase
    end

    // reset mid-operation with key[3] held through it
    key = 4'h7;
    repeat (20) step();
    peek(CTRL_A, 32'h0001_0301, "pre_rst_ctrl");
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    peek(CTRL_A, 32'h0, "mid_rst_ctrl");
    peek(DATA_A, 32'h0, "mid_rst_data");
    check("mid_rst_intr", {31'b0, intr}, 32'h0);
    repeat (17) step();
    peek(DATA_A, 32'h0, "redetect_edge17");
    step();
    peek(DATA_A, 32'h8, "redetect_edge18");
    peek(CTRL_A, 32'h0001_0001, "redetect_evt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
